// File: rtl/ev_chk_pkg.sv
// Shared types and constants for the count-sequence checker tile.
// Pure declarations: no logic, no latency.
// Bit indices refer to the Tiny Tapeout uio bus of the checker.
package ev_chk_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } chk_state_e;

    // uio_in control bits
    localparam int UIO_STROBE = 0;
    localparam int UIO_CLR    = 1;
    localparam int UIO_SEL    = 2;
    localparam int UIO_DIR    = 3;

    // uio_out status bits (upper nibble only, lower nibble stays input)
    localparam int UIO_LOCKED = 4;
    localparam int UIO_ERRP   = 5;
    localparam int UIO_SAT    = 6;
    localparam int UIO_ACQ    = 7;

    localparam logic [7:0] UIO_OE_VAL = 8'hF0;

endpackage

// File: rtl/ev_sat_counter.sv
// Saturating error counter with synchronous clear that beats increment.
// Latency: count and sat flag update on the clock edge after inc/clr.
// No backpressure: en_i low holds the count and the flag.
module ev_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o,
    output logic         sat_o
);

    localparam logic [W-1:0] MAX_VAL = {W{1'b1}};

    logic [W-1:0] cnt_q, cnt_d;
    logic         sat_q, sat_d;

    // Next count: clear wins, increment stops at all-ones and raises sat.
    always_comb begin
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (en_i) begin
            if (clr_i) begin
                cnt_d = '0;
                sat_d = 1'b0;
            end else if (inc_i && (cnt_q != MAX_VAL)) begin
                cnt_d = cnt_q + W'(1);
                sat_d = (cnt_d == MAX_VAL);
            end
        end
    end

    // Count and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    assign cnt_o = cnt_q;
    assign sat_o = sat_q;

endmodule

// File: rtl/tt_um_ev_count_checker.sv
// Checks a strobed external count stream for +1 steps, locks, counts errors.
// Latency: status/err pulse one cycle after the sampling edge; uo_out mux is combinational on sel.
// No backpressure: ena low freezes all state. Macro CHK_DIR_EN adds down-count checking.
module tt_um_ev_count_checker
    import ev_chk_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] ui_in,
    input  logic [7:0]       uio_in,
    output logic [WIDTH-1:0] uo_out,
    output logic [7:0]       uio_out,
    output logic [7:0]       uio_oe
);

    localparam logic [7:0] LOCK_L = 8'(LOCK_COUNT);
    localparam logic [7:0] LOSS_L = 8'(LOSS_COUNT);

    chk_state_e       state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [7:0]       streak_q, streak_d;
    logic [7:0]       miss_q, miss_d;
    logic             err_pulse_q, err_pulse_d;
    logic             err_inc;
    logic [WIDTH-1:0] expected;
    logic             match;
    logic [WIDTH-1:0] err_cnt;
    logic             err_sat;

`ifdef CHK_DIR_EN
    logic dir_q, dir_d;
    logic unused_uio;
    assign unused_uio = &{1'b0, uio_in[7:4]};
    // Down-count mode expects a decrement; 0 wraps to all-ones.
    assign expected = uio_in[UIO_DIR] ? (prev_q - WIDTH'(1)) : (prev_q + WIDTH'(1));
`else
    logic unused_uio;
    assign unused_uio = &{1'b0, uio_in[7:3]};
    assign expected = prev_q + WIDTH'(1);
`endif

    assign match = (ui_in == expected);

    // Sequence tracking: acquire on consecutive matches, drop after repeated misses.
    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        streak_d    = streak_q;
        miss_d      = miss_q;
        err_pulse_d = err_pulse_q;
        err_inc     = 1'b0;
`ifdef CHK_DIR_EN
        dir_d       = dir_q;
`endif
        if (ena) begin
            err_pulse_d = 1'b0;
            if (uio_in[UIO_STROBE]) begin
                prev_d = ui_in;
                case (state_q)
                    SEARCH: begin
                        state_d  = ACQUIRE;
                        streak_d = 8'd0;
                    end
                    ACQUIRE: begin
                        if (match) begin
                            if (streak_q + 8'd1 == LOCK_L) begin
                                state_d = LOCKED;
                                miss_d  = 8'd0;
                            end else begin
                                streak_d = streak_q + 8'd1;
                            end
                        end else begin
                            streak_d = 8'd0;
                        end
                    end
                    LOCKED: begin
                        if (match) begin
                            miss_d = 8'd0;
                        end else begin
                            // The miss that loses lock is still an error.
                            err_inc     = 1'b1;
                            err_pulse_d = 1'b1;
                            if (miss_q + 8'd1 == LOSS_L) begin
                                state_d  = ACQUIRE;
                                streak_d = 8'd0;
                            end else begin
                                miss_d = miss_q + 8'd1;
                            end
                        end
                    end
                    default: state_d = SEARCH;
                endcase
            end
`ifdef CHK_DIR_EN
            // A direction flip invalidates the current lock; re-acquire without blame.
            dir_d = uio_in[UIO_DIR];
            if (uio_in[UIO_DIR] != dir_q) begin
                state_d     = ACQUIRE;
                streak_d    = 8'd0;
                err_inc     = 1'b0;
                err_pulse_d = 1'b0;
            end
`endif
        end
    end

    // Tracker state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SEARCH;
            prev_q      <= '0;
            streak_q    <= 8'd0;
            miss_q      <= 8'd0;
            err_pulse_q <= 1'b0;
`ifdef CHK_DIR_EN
            dir_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            streak_q    <= streak_d;
            miss_q      <= miss_d;
            err_pulse_q <= err_pulse_d;
`ifdef CHK_DIR_EN
            dir_q       <= dir_d;
`endif
        end
    end

    ev_sat_counter #(
        .W (WIDTH)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (ena),
        .clr_i (uio_in[UIO_CLR]),
        .inc_i (err_inc),
        .cnt_o (err_cnt),
        .sat_o (err_sat)
    );

    // Output assembly from registered state; only the uo_out select is live.
    always_comb begin
        uio_out             = 8'h00;
        uio_out[UIO_LOCKED] = (state_q == LOCKED);
        uio_out[UIO_ERRP]   = err_pulse_q;
        uio_out[UIO_SAT]    = err_sat;
        uio_out[UIO_ACQ]    = (state_q == ACQUIRE);
        uo_out              = uio_in[UIO_SEL] ? prev_q : err_cnt;
    end

    assign uio_oe = UIO_OE_VAL;

endmodule
